// File: rtl/fifo_rr_reader_pkg.sv
// Shared constants for the round-robin fifo reader.
// Holds boolean helpers, default geometry and the fifo read latency.
package fifo_rr_reader_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic ONE   = 1'b1;
  localparam logic ZERO  = 1'b0;

  localparam int unsigned WIDTH_D           = 32;
  localparam int unsigned CH_BITS_D         = 2;
  localparam int unsigned Q_DEPTH_IN_BITS_D = 2;

  localparam int unsigned N = 1 << CH_BITS_D;
  localparam int unsigned Q = 1 << Q_DEPTH_IN_BITS_D;

  // Cycles from fifo req_r to valid_r; the attached fifos use the same value.
  localparam int unsigned READ_LATENCY = 2;

endpackage

// File: rtl/fifo_rr_reader_reg_queue.sv
// First-word-fall-through register queue with occupancy count.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   i_push      : write i_data (dropped and flagged on o_overflow when full)
//   i_data      : word to write
//   i_pop       : consume the head word
//   o_valid     : queue non-empty
//   o_data      : head word (stable until popped)
//   o_count     : occupancy, one bit wider than the pointers
//   o_overflow  : push attempted while full
module fifo_rr_reader_reg_queue
  import fifo_rr_reader_pkg::*;
#(
  parameter int unsigned DW         = 34,
  parameter int unsigned DEPTH_BITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [DW-1:0]         i_data,
  input  logic                  i_pop,
  output logic                  o_valid,
  output logic [DW-1:0]         o_data,
  output logic [DEPTH_BITS:0]   o_count,
  output logic                  o_overflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_BITS;
  localparam int unsigned CW    = DEPTH_BITS + 1;

  logic [DW-1:0]         r_mem [DEPTH];
  logic [DEPTH_BITS-1:0] r_wr_ptr;
  logic [DEPTH_BITS-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic w_full;
  logic w_wr_en;
  logic w_rd_en;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_wr_en = i_push && !w_full;
  assign w_rd_en = i_pop && (r_count != '0);

  // Storage, pointers and count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + DEPTH_BITS'(ONE);
      end
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + DEPTH_BITS'(ONE);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid    = (r_count != '0);
  assign o_data     = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_overflow = i_push && w_full;

endmodule

// File: rtl/fifo_rr_reader.sv
// Round-robin read scheduler draining several fifos into one valid/ready stream.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   ch_enable     : per-channel service enable
//   fifo_empty    : empty flag of each fifo
//   fifo_req_r    : one-hot read request (combinational)
//   fifo_valid_r  : valid_r of each fifo, READ_LATENCY after req_r
//   fifo_data_r   : data_r of each fifo, channel i at [i*WIDTH +: WIDTH]
//   out_data/out_ch/out_valid/out_ready : head word stream
//   busy          : reads in flight or words queued
//   err           : sticky protocol error
module fifo_rr_reader
  import fifo_rr_reader_pkg::*;
#(
  parameter int unsigned WIDTH           = WIDTH_D,
  parameter int unsigned CH_BITS         = CH_BITS_D,
  parameter int unsigned Q_DEPTH_IN_BITS = Q_DEPTH_IN_BITS_D
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [(1<<CH_BITS)-1:0]           ch_enable,
  input  logic [(1<<CH_BITS)-1:0]           fifo_empty,
  output logic [(1<<CH_BITS)-1:0]           fifo_req_r,
  input  logic [(1<<CH_BITS)-1:0]           fifo_valid_r,
  input  logic [(1<<CH_BITS)*WIDTH-1:0]     fifo_data_r,
  output logic [WIDTH-1:0]                  out_data,
  output logic [CH_BITS-1:0]                out_ch,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy,
  output logic                              err
);

  localparam int unsigned NCH = 1 << CH_BITS;
  localparam int unsigned QD  = 1 << Q_DEPTH_IN_BITS;
  localparam int unsigned CW  = Q_DEPTH_IN_BITS + 1;
  localparam int unsigned SW  = CW + 1;
  localparam int unsigned LW  = $clog2(READ_LATENCY + 1);

  logic [CH_BITS-1:0]      r_rr_ptr;
  logic [READ_LATENCY-1:0] r_pv;
  logic [CH_BITS-1:0]      r_pch [READ_LATENCY];
  logic                    r_err;

  logic [NCH-1:0]          w_elig;
  logic                    w_found;
  logic [CH_BITS-1:0]      w_gnt;
  logic [CH_BITS-1:0]      w_idx;
  logic [LW-1:0]           w_inflight;
  logic [CW-1:0]           w_q_count;
  logic                    w_credit_ok;
  logic                    w_issue;
  logic                    w_s2_v;
  logic [CH_BITS-1:0]      w_s2_ch;
  logic [NCH-1:0]          w_expect;
  logic                    w_stray;
  logic                    w_miss;
  logic                    w_push;
  logic [WIDTH-1:0]        w_push_data;
  logic                    w_overflow;
  logic [WIDTH+CH_BITS-1:0] w_q_head;

  assign w_elig = ch_enable & ~fifo_empty;

  // First eligible channel searching upward from the rr pointer, with wrap
  always_comb begin
    w_found = FALSE;
    w_gnt   = '0;
    w_idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      w_idx = r_rr_ptr + CH_BITS'(k);
      if (!w_found && w_elig[w_idx]) begin
        w_found = TRUE;
        w_gnt   = w_idx;
      end
    end
  end

  // Number of reads still travelling through the fifo latency
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) w_inflight = w_inflight + LW'(r_pv[i]);
  end

  // Credit: every in-flight read already owns a queue slot; a same-cycle pop is not counted
  assign w_credit_ok = (SW'(w_q_count) + SW'(w_inflight)) < SW'(QD);
  assign w_issue     = w_found && w_credit_ok && !reset;
  assign fifo_req_r  = w_issue ? (NCH'(1) << w_gnt) : '0;

  assign w_s2_v      = r_pv[READ_LATENCY-1];
  assign w_s2_ch     = r_pch[READ_LATENCY-1];
  assign w_expect    = w_s2_v ? (NCH'(1) << w_s2_ch) : '0;
  assign w_stray     = |(fifo_valid_r & ~w_expect);
  assign w_miss      = w_s2_v && !fifo_valid_r[w_s2_ch];
  assign w_push      = w_s2_v && fifo_valid_r[w_s2_ch];
  assign w_push_data = fifo_data_r[w_s2_ch*WIDTH +: WIDTH];

  // Arbiter pointer, in-flight pipeline and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
      r_pv     <= '0;
      for (int i = 0; i < READ_LATENCY; i++) r_pch[i] <= '0;
      r_err    <= ZERO;
    end else begin
      if (w_issue) r_rr_ptr <= w_gnt + CH_BITS'(ONE);
      r_pv     <= {r_pv[READ_LATENCY-2:0], w_issue};
      r_pch[0] <= w_gnt;
      for (int i = 1; i < READ_LATENCY; i++) r_pch[i] <= r_pch[i-1];
      if (w_stray || w_miss || w_overflow) r_err <= TRUE;
    end
  end

  fifo_rr_reader_reg_queue #(
    .DW         (WIDTH + CH_BITS),
    .DEPTH_BITS (Q_DEPTH_IN_BITS)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_data     ({w_s2_ch, w_push_data}),
    .i_pop      (out_valid && out_ready),
    .o_valid    (out_valid),
    .o_data     (w_q_head),
    .o_count    (w_q_count),
    .o_overflow (w_overflow)
  );

  assign out_ch   = w_q_head[WIDTH +: CH_BITS];
  assign out_data = w_q_head[WIDTH-1:0];
  assign busy     = (w_inflight != '0) || (w_q_count != '0);
  assign err      = r_err;

endmodule
